// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx -- PS/2 keyboard receiver.
//
// Synchronises and de-glitches the raw keyboard clock/data lines, assembles
// 11-bit frames (start, 8 data bits LSB-first, odd parity, stop) with a
// per-frame timeout, folds the E0/F0 prefixes into single key events and
// keeps a short history of pressed keys with auto-repeat suppression.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous reset, active-low
//   kbclk      in   raw PS/2 clock (asynchronous)
//   in         in   raw PS/2 data (asynchronous)
//   code_valid out  one-cycle pulse, key event available
//   code       out  scan code of the last event (prefixes stripped)
//   ext        out  last event carried the E0 prefix
//   brk        out  last event was a release (F0 prefix)
//   frame_err  out  one-cycle pulse on parity, stop or timeout error
//   history    out  pressed-key history, [7:0] newest
module ps2_kbd_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int TIMEOUT     = 50000,
  parameter int N_BYTES     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   kbclk,
  input  logic                   in,
  output logic                   code_valid,
  output logic [7:0]             code,
  output logic                   ext,
  output logic                   brk,
  output logic                   frame_err,
  output logic [8*N_BYTES-1:0]   history
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ------------------------------------------------------------------
  // Input synchronisers (reset to the idle-high line level)
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] kbclk_sync_q;
  logic [SYNC_STAGES-1:0] in_sync_q;
  logic                   kbclk_s;
  logic                   in_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kbclk_sync_q <= '1;
      in_sync_q    <= '1;
    end else begin
      kbclk_sync_q <= {kbclk_sync_q[SYNC_STAGES-2:0], kbclk};
      in_sync_q    <= {in_sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign kbclk_s = kbclk_sync_q[SYNC_STAGES-1];
  assign in_s    = in_sync_q[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // kbclk filter and falling-edge strobe.
  // deb_cnt_q counts consecutive cycles the synchronised clock disagrees
  // with the filtered one; the filtered level flips on the DEB_CYCLES-th.
  // strobe_q is high in the first cycle the filtered clock reads 0.
  // ------------------------------------------------------------------
  logic          filt_q;
  logic [DW-1:0] deb_cnt_q;
  logic          strobe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q    <= 1'b1;
      deb_cnt_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (kbclk_s != filt_q) begin
        if (deb_cnt_q == DEB_MAX) begin
          filt_q    <= kbclk_s;
          deb_cnt_q <= '0;
          strobe_q  <= ~kbclk_s;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Frame FSM, prefix decode and key history
  // ------------------------------------------------------------------
  state_t                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   par_q;
  logic [TW-1:0]          tmo_cnt_q;
  logic                   ext_pend_q;
  logic                   brk_pend_q;
  logic [8:0]             lock_q;
  logic                   lock_vld_q;
  logic                   code_valid_q;
  logic [7:0]             code_q;
  logic                   ext_q;
  logic                   brk_q;
  logic                   frame_err_q;
  logic [8*N_BYTES-1:0]   history_q;

  logic                   frame_ok_d;
  logic [8:0]             key_d;
  logic                   new_key_d;
  logic [8*N_BYTES+7:0]   hist_shift_d;

  always_comb begin
    frame_ok_d   = in_s & (^{shift_q, par_q});
    key_d        = {ext_pend_q, shift_q};
    new_key_d    = !lock_vld_q || (lock_q != key_d);
    // Widened by one byte so the shift also works for N_BYTES == 1.
    hist_shift_d = {history_q, shift_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      lock_q       <= '0;
      lock_vld_q   <= 1'b0;
      code_valid_q <= 1'b0;
      code_q       <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      history_q    <= '0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (strobe_q) begin
        // A strobe always restarts the timeout, even if it coincides
        // with the terminal count.
        tmo_cnt_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (!in_s) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q   <= {in_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= in_s;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (frame_ok_d) begin
              if (shift_q == 8'hE0) begin
                ext_pend_q <= 1'b1;
              end else if (shift_q == 8'hF0) begin
                brk_pend_q <= 1'b1;
              end else begin
                code_valid_q <= 1'b1;
                code_q       <= shift_q;
                ext_q        <= ext_pend_q;
                brk_q        <= brk_pend_q;
                ext_pend_q   <= 1'b0;
                brk_pend_q   <= 1'b0;
                if (!brk_pend_q) begin
                  // Make: only a key different from the held one enters
                  // the history; repeats of the held key are dropped.
                  if (new_key_d) history_q <= hist_shift_d[8*N_BYTES-1:0];
                  lock_q     <= key_d;
                  lock_vld_q <= 1'b1;
                end else if (lock_vld_q && (lock_q == key_d)) begin
                  lock_vld_q <= 1'b0;
                end
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_pend_q  <= 1'b0;
              brk_pend_q  <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        if (tmo_cnt_q == TMO_MAX) begin
          state_q     <= S_IDLE;
          tmo_cnt_q   <= '0;
          frame_err_q <= 1'b1;
          ext_pend_q  <= 1'b0;
          brk_pend_q  <= 1'b0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end
    end
  end

  assign code_valid = code_valid_q;
  assign code       = code_q;
  assign ext        = ext_q;
  assign brk        = brk_q;
  assign frame_err  = frame_err_q;
  assign history    = history_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx -- self-checking bench for ps2_kbd_rx.
// Drives PS/2 frames on kbclk/in; expected key events are queued when a
// frame is sent and checked by a monitor when code_valid pulses.
module tb_ps2_kbd_rx;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int TMO  = 300;
  localparam int NB   = 2;
  localparam int HALF = 20;
  localparam int LAT  = SYNC + DEB + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            kbclk = 1'b1;
  logic            ps2_in = 1'b1;
  logic            code_valid;
  logic [7:0]      code;
  logic            ext;
  logic            brk;
  logic            frame_err;
  logic [8*NB-1:0] history;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (DEB),
    .TIMEOUT    (TMO),
    .N_BYTES    (NB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kbclk     (kbclk),
    .in        (ps2_in),
    .code_valid(code_valid),
    .code      (code),
    .ext       (ext),
    .brk       (brk),
    .frame_err (frame_err),
    .history   (history)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  ev_t  exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   valid_seen = 0;
  int   err_seen = 0;
  logic m_ext = 1'b0;
  logic m_brk = 1'b0;

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst_n) begin
      if (code_valid) begin
        valid_seen++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got code=%h ext=%b brk=%b, required no event", code, ext, brk);
        end else begin
          e = exp_q.pop_front();
          if ({code, ext, brk} !== e) begin
            n_fail++;
            $display("FAIL event: got code=%h ext=%b brk=%b, required code=%h ext=%b brk=%b",
                     code, ext, brk, e.code, e.ext, e.brk);
          end
        end
      end
      if (frame_err) err_seen++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_byte(input logic [7:0] b, input logic ok);
    ev_t e;
    if (!ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      e.code = b;
      e.ext  = m_ext;
      e.brk  = m_brk;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Sends one frame; lat = posedges from the stop-bit clock fall until
  // code_valid is seen (-1 if never within the low half).
  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop, output int lat);
    logic        p;
    logic [10:0] f;
    p = (~^b) ^ bad_par;
    f = {~bad_stop, p, b, 1'b0};
    model_byte(b, !bad_par && !bad_stop);
    lat = -1;
    for (int i = 0; i < 11; i++) begin
      ps2_in = f[i];
      repeat (HALF) @(posedge clk);
      #1 kbclk = 1'b0;
      for (int c = 1; c <= HALF; c++) begin
        @(posedge clk);
        #1;
        if (i == 10 && lat < 0 && code_valid) lat = c;
      end
      kbclk = 1'b1;
    end
    ps2_in = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int lat;
    send_frame(b, 1'b0, 1'b0, lat);
  endtask

  // Start bit plus n data bits, then the line goes idle.
  task automatic send_partial(input int n);
    logic [7:0] pat;
    pat = 8'b0101_1010;
    for (int i = 0; i <= n; i++) begin
      ps2_in = (i == 0) ? 1'b0 : pat[i-1];
      repeat (HALF) @(posedge clk);
      #1 kbclk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 kbclk = 1'b1;
    end
    ps2_in = 1'b1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    kbclk  = 1'b1;
    ps2_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_assert += 6;
    if (code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_code_valid: got %b required 0", code_valid); end
    if (code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h required 00", code); end
    if (ext !== 1'b0) begin n_fail++; $display("FAIL reset_ext: got %b required 0", ext); end
    if (brk !== 1'b0) begin n_fail++; $display("FAIL reset_brk: got %b required 0", brk); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
    if (history !== '0) begin n_fail++; $display("FAIL reset_history: got %h required 0000", history); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int lat;
    int v0;
    v0 = valid_seen;
    send_frame(8'h1C, 1'b0, 1'b0, lat);
    n_assert += 5;
    if (lat != LAT) begin n_fail++; $display("FAIL single_latency: got %0d required %0d", lat, LAT); end
    if (valid_seen - v0 != 1) begin n_fail++; $display("FAIL single_pulses: got %0d required 1", valid_seen - v0); end
    if (code !== 8'h1C) begin n_fail++; $display("FAIL single_code_hold: got %h required 1c", code); end
    if ({ext, brk} !== 2'b00) begin n_fail++; $display("FAIL single_ext_brk: got %b required 00", {ext, brk}); end
    if (history[7:0] !== 8'h1C) begin n_fail++; $display("FAIL single_history: got %h required 1c", history[7:0]); end
  endtask

  task automatic test_back_to_back();
    int v0;
    do_reset();
    v0 = valid_seen;
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    send(8'h32);
    n_assert += 3;
    if (valid_seen - v0 != 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d required 3", valid_seen - v0); end
    if (history !== 16'h1C32) begin n_fail++; $display("FAIL b2b_history: got %h required 1c32", history); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_extended();
    int v0;
    v0 = valid_seen;
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    n_assert += 3;
    if (valid_seen - v0 != 2) begin n_fail++; $display("FAIL ext_pulses: got %0d required 2", valid_seen - v0); end
    if ({code, ext, brk} !== {8'h75, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ext_hold: got code=%h ext=%b brk=%b required 75 1 1", code, ext, brk);
    end
    if (history !== 16'h3275) begin n_fail++; $display("FAIL ext_history: got %h required 3275", history); end
  endtask

  task automatic test_auto_repeat();
    int v0;
    v0 = valid_seen;
    for (int i = 0; i < 3; i++) send(8'h1C);
    n_assert += 2;
    if (valid_seen - v0 != 3) begin n_fail++; $display("FAIL repeat_pulses: got %0d required 3", valid_seen - v0); end
    if (history !== 16'h751C) begin n_fail++; $display("FAIL repeat_history: got %h required 751c", history); end
  endtask

  task automatic test_errors();
    int v0;
    int e0;
    int lat;
    v0 = valid_seen;
    e0 = err_seen;
    send_frame(8'h1C, 1'b1, 1'b0, lat);
    send_frame(8'hF0, 1'b0, 1'b1, lat);
    n_assert += 2;
    if (err_seen - e0 != 2) begin n_fail++; $display("FAIL err_count_a: got %0d required 2", err_seen - e0); end
    if (valid_seen - v0 != 0) begin n_fail++; $display("FAIL err_no_event: got %0d required 0", valid_seen - v0); end
    // A good break prefix followed by a corrupted frame must be forgotten.
    send(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0, lat);
    send(8'h1C);
    n_assert += 4;
    if (err_seen - e0 != 3) begin n_fail++; $display("FAIL err_count_b: got %0d required 3", err_seen - e0); end
    if (valid_seen - v0 != 1) begin n_fail++; $display("FAIL err_recover_pulses: got %0d required 1", valid_seen - v0); end
    if (brk !== 1'b0) begin n_fail++; $display("FAIL err_brk_cleared: got %b required 0", brk); end
    if (history !== 16'h751C) begin n_fail++; $display("FAIL err_history: got %h required 751c", history); end
  endtask

  task automatic test_timeout();
    int v0;
    int e0;
    send(8'hE0);
    v0 = valid_seen;
    e0 = err_seen;
    send_partial(4);
    model_byte(8'h00, 1'b0);
    repeat (TMO + 100) @(posedge clk);
    #1;
    n_assert += 2;
    if (err_seen - e0 != 1) begin n_fail++; $display("FAIL timeout_err: got %0d required 1", err_seen - e0); end
    if (valid_seen - v0 != 0) begin n_fail++; $display("FAIL timeout_no_event: got %0d required 0", valid_seen - v0); end
    send(8'h1C);
    n_assert += 3;
    if (valid_seen - v0 != 1) begin n_fail++; $display("FAIL timeout_recover: got %0d required 1", valid_seen - v0); end
    if ({code, ext, brk} !== {8'h1C, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL timeout_event: got code=%h ext=%b brk=%b required 1c 0 0", code, ext, brk);
    end
    if (err_seen - e0 != 1) begin n_fail++; $display("FAIL timeout_err_after: got %0d required 1", err_seen - e0); end
  endtask

  task automatic test_reset_midframe();
    int v0;
    int e0;
    send_partial(3);
    rst_n  = 1'b0;
    kbclk  = 1'b1;
    ps2_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_assert += 2;
    if ({code_valid, code, ext, brk, frame_err} !== 12'h000) begin
      n_fail++; $display("FAIL midreset_outputs: got %h required 000", {code_valid, code, ext, brk, frame_err});
    end
    if (history !== '0) begin n_fail++; $display("FAIL midreset_history: got %h required 0000", history); end
    rst_n = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    v0 = valid_seen;
    e0 = err_seen;
    repeat (TMO + 100) @(posedge clk);
    #1;
    n_assert += 2;
    if (valid_seen - v0 != 0) begin n_fail++; $display("FAIL midreset_valid: got %0d required 0", valid_seen - v0); end
    if (err_seen - e0 != 0) begin n_fail++; $display("FAIL midreset_err: got %0d required 0", err_seen - e0); end
    send(8'h1C);
    n_assert += 2;
    if (valid_seen - v0 != 1) begin n_fail++; $display("FAIL midreset_after: got %0d required 1", valid_seen - v0); end
    if (history !== 16'h001C) begin n_fail++; $display("FAIL midreset_history_after: got %h required 001c", history); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_extended();
    test_auto_repeat();
    test_errors();
    test_timeout();
    test_reset_midframe();
    n_assert++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL missing_events: got %0d outstanding required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
